// File: rtl/msx_slot_pkg.sv
// msx_slot_pkg: shared constants and helpers for the MSX slot expander
package msx_slot_pkg;
    localparam int SLOT_W = 2;
    localparam int PAGE_W = 2;
    localparam logic [15:0] SUBSLOT_ADDR = 16'hFFFF;
    localparam logic [5:0] MAPPER_PORT_HI = 6'b111111;
    // Power-on mapping: page0..3 -> segment 3,2,1,0
    localparam logic [3:0][1:0] MAP_RST = {2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic [3:0] onehot_n(input logic [SLOT_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/msx_mapper_regs.sv
// msx_mapper_regs: four RAM mapper page registers on I/O ports 0xFC-0xFF
module msx_mapper_regs
    import msx_slot_pkg::*;
#(
    parameter int MAPPER_BITS = 3,
    parameter bit MAPPER_EN   = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      wr_stb_i,
    input  logic [7:0]                port_i,
    input  logic [PAGE_W-1:0]         page_i,
    input  logic [MAPPER_BITS-1:0]    wd_i,
    input  logic                      mreq_n_i,
    input  logic                      iorq_n_i,
    input  logic                      m1_n_i,
    input  logic                      rd_n_i,
    output logic [MAPPER_BITS-1:0]    seg_o,
    output logic [7:0]                rd_data_o,
    output logic                      rd_oe_o
);
    localparam logic [7:0] SEG_MASK = 8'((1 << MAPPER_BITS) - 1);

    logic [MAPPER_BITS-1:0] map_q [4];
    logic [MAPPER_BITS-1:0] map_d [4];
    logic                   io_act;

    // I/O decode, readback and page-to-segment translation; memory cycles take precedence over I/O
    always_comb begin
        io_act    = MAPPER_EN && !iorq_n_i && m1_n_i && mreq_n_i && port_i[7:2] == MAPPER_PORT_HI;
        rd_oe_o   = io_act && !rd_n_i;
        rd_data_o = rd_oe_o ? (~SEG_MASK | 8'(map_q[port_i[1:0]])) : 8'h00;
        seg_o     = MAPPER_EN ? map_q[page_i] : MAPPER_BITS'(page_i);
        for (int i = 0; i < 4; i++)
            map_d[i] = (wr_stb_i && io_act && port_i[1:0] == 2'(i)) ? wd_i : map_q[i];
    end

    // Page register storage with power-on mapping
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 4; i++) map_q[i] <= MAPPER_BITS'(MAP_RST[i]);
        end else begin
            map_q <= map_d;
        end
    end
endmodule

// File: rtl/msx_slot_expander.sv
// msx_slot_expander: primary/secondary slot decoder with I/O-port RAM mapper
module msx_slot_expander
    import msx_slot_pkg::*;
#(
    parameter logic [3:0] EXPANDED    = 4'b1000,
    parameter int         MAPPER_BITS = 3,
    parameter bit         MAPPER_EN   = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [15:0]               addr_i,
    input  logic [7:0]                data_i,
    input  logic                      mreq_n_i,
    input  logic                      iorq_n_i,
    input  logic                      m1_n_i,
    input  logic                      rd_n_i,
    input  logic                      wr_n_i,
    input  logic                      rfsh_n_i,
    input  logic [7:0]                psl_i,
    output logic [7:0]                data_o,
    output logic                      data_oe_o,
    output logic [3:0]                sltsl_n_o,
    output logic [3:0]                subsl_n_o,
    output logic [MAPPER_BITS+13:0]   ram_addr_o
);
    logic [PAGE_W-1:0]      page;
    logic [SLOT_W-1:0]      pslot;
    logic                   mem_act;
    logic                   exp_hit;
    logic                   ffff_hit;
    logic                   ffff_rd;
    logic                   wr_stb;
    logic [7:0]             sub_q [4];
    logic [7:0]             sub_d [4];
    logic                   wr_n_q;
    logic                   wr_n_d;
    logic                   armed_q;
    logic                   armed_d;
    logic [MAPPER_BITS-1:0] seg;
    logic [7:0]             map_data;
    logic                   map_oe;

    // Bus decode: page, primary slot, subslot-register hit and the one-shot write strobe
    always_comb begin
        page     = addr_i[15:14];
        pslot    = psl_i[{page, 1'b0} +: 2];
        mem_act  = !mreq_n_i && rfsh_n_i;
        exp_hit  = EXPANDED[pslot];
        ffff_hit = mem_act && exp_hit && addr_i == SUBSLOT_ADDR;
        ffff_rd  = ffff_hit && !rd_n_i;
        wr_stb   = !wr_n_i && wr_n_q && armed_q;
    end

    // Slot selects and CPU readback; the FFFF register owns its cycle so no subslot is selected
    always_comb begin
        sltsl_n_o  = mem_act ? onehot_n(pslot) : 4'hF;
        subsl_n_o  = (mem_act && exp_hit && !ffff_hit) ? onehot_n(sub_q[pslot][{page, 1'b0} +: 2]) : 4'hF;
        data_oe_o  = ffff_rd || map_oe;
        data_o     = ffff_rd ? ~sub_q[pslot] : map_data;
        ram_addr_o = {seg, addr_i[13:0]};
    end

    // Next state: WR_n history, strobe arming after reset, subslot register loads
    always_comb begin
        wr_n_d  = wr_n_i;
        armed_d = armed_q || wr_n_i;
        for (int i = 0; i < 4; i++)
            sub_d[i] = (wr_stb && ffff_hit && pslot == 2'(i)) ? data_i : sub_q[i];
    end

    // State registers; disarmed after reset until WR_n has been seen high on a clock
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_n_q  <= 1'b1;
            armed_q <= 1'b0;
            for (int i = 0; i < 4; i++) sub_q[i] <= 8'h00;
        end else begin
            wr_n_q  <= wr_n_d;
            armed_q <= armed_d;
            sub_q   <= sub_d;
        end
    end

    msx_mapper_regs #(
        .MAPPER_BITS(MAPPER_BITS),
        .MAPPER_EN  (MAPPER_EN)
    ) u_mapper (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .wr_stb_i (wr_stb),
        .port_i   (addr_i[7:0]),
        .page_i   (page),
        .wd_i     (data_i[MAPPER_BITS-1:0]),
        .mreq_n_i (mreq_n_i),
        .iorq_n_i (iorq_n_i),
        .m1_n_i   (m1_n_i),
        .rd_n_i   (rd_n_i),
        .seg_o    (seg),
        .rd_data_o(map_data),
        .rd_oe_o  (map_oe)
    );
endmodule
